// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shift engine: MSB-first full-duplex frame of DATA_W bits.
// Registered outputs; spi_clk generated from a HALF_PERIOD-cycle counter.
module spi_master_shifter #(
  parameter int DATA_W      = 32,
  parameter int HALF_PERIOD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_dv,
  output logic              spi_clk,
  output logic              mosi_out,
  input  logic              miso_in
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [HW-1:0]     r_hcnt, w_hcnt_nxt;
  logic [BW-1:0]     r_bcnt, w_bcnt_nxt;
  logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_dv, w_rx_dv_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_mosi, w_mosi_nxt;
  logic              r_ready, w_ready_nxt;
  logic              w_hc_last;
  logic              w_bc_last;

  assign w_hc_last = (r_hcnt == HW'(HALF_PERIOD - 1));
  assign w_bc_last = (r_bcnt == BW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hcnt    <= '0;
      r_bcnt    <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_rx_dv   <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_tx_sh   <= w_tx_sh_nxt;
      r_rx_sh   <= w_rx_sh_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_rx_dv   <= w_rx_dv_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hcnt_nxt    = r_hcnt;
    w_bcnt_nxt    = r_bcnt;
    w_tx_sh_nxt   = r_tx_sh;
    w_rx_sh_nxt   = r_rx_sh;
    w_rx_data_nxt = r_rx_data;
    w_rx_dv_nxt   = 1'b0;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_ready_nxt   = r_ready;
    unique case (r_state)
      S_IDLE: begin
        if (tx_load) begin
          w_state_nxt = S_LOW;
          w_tx_sh_nxt = tx_data;
          w_mosi_nxt  = tx_data[DATA_W-1];
          w_hcnt_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_ready_nxt = 1'b0;
        end
      end
      S_LOW: begin
        if (w_hc_last) begin
          w_state_nxt = S_HIGH;
          w_hcnt_nxt  = '0;
          w_sclk_nxt  = 1'b1;
          // sample on the rising edge, assembling MSB first
          w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], miso_in};
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      S_HIGH: begin
        if (w_hc_last) begin
          w_hcnt_nxt = '0;
          w_sclk_nxt = 1'b0;
          if (w_bc_last) begin
            w_state_nxt   = S_IDLE;
            w_mosi_nxt    = 1'b0;
            w_rx_data_nxt = r_rx_sh;
            w_rx_dv_nxt   = 1'b1;
            w_ready_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_LOW;
            w_bcnt_nxt  = r_bcnt + BW'(1);
            w_tx_sh_nxt = {r_tx_sh[DATA_W-2:0], 1'b0};
            w_mosi_nxt  = r_tx_sh[DATA_W-2];
          end
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx_ready = r_ready;
  assign rx_ready = r_ready;
  assign rx_data  = r_rx_data;
  assign rx_dv    = r_rx_dv;
  assign spi_clk  = r_sclk;
  assign mosi_out = r_mosi;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter: HALF_PERIOD=1 and =3 instances.
// Frames are traced cycle by cycle and compared to hand-derived values.
module tb_spi_master_shifter;

  logic        clk;
  logic        rst;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        sel;
  logic        lb;
  logic        miso_c;

  logic        txr1, rxr1, dv1, sclk1, mosi1, miso1;
  logic        txr3, rxr3, dv3, sclk3, mosi3, miso3;
  logic [31:0] rxd1, rxd3;

  logic        w_txr, w_rxr, w_dv, w_sclk, w_mosi;
  logic [31:0] w_rxd;

  int n_chk;
  int n_pass;

  assign miso1 = lb ? mosi1 : miso_c;
  assign miso3 = lb ? mosi3 : miso_c;

  assign w_txr  = sel ? txr3  : txr1;
  assign w_rxr  = sel ? rxr3  : rxr1;
  assign w_dv   = sel ? dv3   : dv1;
  assign w_sclk = sel ? sclk3 : sclk1;
  assign w_mosi = sel ? mosi3 : mosi1;
  assign w_rxd  = sel ? rxd3  : rxd1;

  spi_master_shifter #(.DATA_W(32), .HALF_PERIOD(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_load  (tx_load & ~sel),
    .tx_ready (txr1),
    .rx_ready (rxr1),
    .rx_data  (rxd1),
    .rx_dv    (dv1),
    .spi_clk  (sclk1),
    .mosi_out (mosi1),
    .miso_in  (miso1)
  );

  spi_master_shifter #(.DATA_W(32), .HALF_PERIOD(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_load  (tx_load & sel),
    .tx_ready (txr3),
    .rx_ready (rxr3),
    .rx_data  (rxd3),
    .rx_dv    (dv3),
    .spi_clk  (sclk3),
    .mosi_out (mosi3),
    .miso_in  (miso3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Caller is positioned 1 time unit after an edge. Load goes in now;
  // ign_at>0 pulses a 0xDEADBEEF load at that cycle of the frame.
  task automatic run_frame(input logic [31:0] d, input int ign_at,
                           output logic [31:0] mo, output int rises,
                           output int lat, output int dvs,
                           output int bad_edge);
    logic prev_c, prev_m;
    mo = '0;
    rises = 0;
    lat = -1;
    dvs = 0;
    bad_edge = 0;
    tx_data = d;
    tx_load = 1'b1;
    @(posedge clk);
    #1;
    tx_load = 1'b0;
    tx_data = 32'h0;
    prev_c = w_sclk;
    prev_m = w_mosi;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (w_sclk && !prev_c) begin
        rises++;
        mo = {mo[30:0], w_mosi};
        if (w_mosi !== prev_m) bad_edge++;
      end
      if (w_dv) dvs++;
      prev_c = w_sclk;
      prev_m = w_mosi;
      if (w_txr) begin
        lat = n;
        break;
      end
      if (n == ign_at) begin
        tx_data = 32'hDEADBEEF;
        tx_load = 1'b1;
      end else begin
        tx_load = 1'b0;
      end
    end
    tx_load = 1'b0;
    if (lat < 0) $display("FAIL frame_timeout: got none expected ready");
  endtask

  logic [31:0] mo;
  int rises, lat, dvs, bad;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    tx_load = 1'b0;
    tx_data = 32'h0;
    sel = 1'b0;
    lb = 1'b0;
    miso_c = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_txr", {31'h0, w_txr}, 32'h1);
    chk("idle_rxr", {31'h0, w_rxr}, 32'h1);
    chk("idle_dv", {31'h0, w_dv}, 32'h0);
    chk("idle_sclk", {31'h0, w_sclk}, 32'h0);
    chk("idle_mosi", {31'h0, w_mosi}, 32'h0);
    chk("idle_rxd", w_rxd, 32'h0);

    run_frame(32'hA5A5F00F, 0, mo, rises, lat, dvs, bad);
    chk("a5_mosi", mo, 32'hA5A5F00F);
    chk("a5_rises", rises, 32);
    chk("a5_lat", lat, 64);
    chk("a5_dv_now", {31'h0, w_dv}, 32'h1);
    chk("a5_rxr", {31'h0, w_rxr}, 32'h1);
    chk("a5_rxd", w_rxd, 32'hFFFFFFFF);
    chk("a5_edge", bad, 0);
    @(posedge clk);
    #1;
    chk("a5_dv_once", {31'h0, w_dv}, 32'h0);
    chk("a5_hold", w_rxd, 32'hFFFFFFFF);

    lb = 1'b1;
    run_frame(32'h12345678, 0, mo, rises, lat, dvs, bad);
    chk("lb_rxd", w_rxd, 32'h12345678);
    chk("lb_dvs", dvs, 1);
    chk("lb_lat", lat, 64);

    sel = 1'b1;
    run_frame(32'h12345678, 0, mo, rises, lat, dvs, bad);
    chk("hp3_rxd", w_rxd, 32'h12345678);
    chk("hp3_lat", lat, 192);
    chk("hp3_rises", rises, 32);
    chk("hp3_dvs", dvs, 1);
    chk("hp3_edge", bad, 0);
    sel = 1'b0;
    @(posedge clk);
    #1;

    run_frame(32'h0000FFFF, 10, mo, rises, lat, dvs, bad);
    chk("ign_mosi", mo, 32'h0000FFFF);
    chk("ign_rxd", w_rxd, 32'h0000FFFF);
    chk("ign_dvs", dvs, 1);
    chk("ign_lat", lat, 64);

    run_frame(32'h80000000, 0, mo, rises, lat, dvs, bad);
    chk("b2b1_rxd", w_rxd, 32'h80000000);
    chk("b2b1_lat", lat, 64);
    run_frame(32'h00000001, 0, mo, rises, lat, dvs, bad);
    chk("b2b2_rxd", w_rxd, 32'h00000001);
    chk("b2b2_lat", lat, 64);
    chk("b2b2_dvs", dvs, 1);

    tx_data = 32'h55555555;
    tx_load = 1'b1;
    @(posedge clk);
    #1;
    tx_load = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_busy", {31'h0, w_txr}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_sclk", {31'h0, w_sclk}, 32'h0);
    chk("rst_txr", {31'h0, w_txr}, 32'h1);
    chk("rst_rxd", w_rxd, 32'h0);
    chk("rst_dv", {31'h0, w_dv}, 32'h0);
    chk("rst_mosi", {31'h0, w_mosi}, 32'h0);

    run_frame(32'hCAFEBABE, 0, mo, rises, lat, dvs, bad);
    chk("cafe_rxd", w_rxd, 32'hCAFEBABE);
    chk("cafe_mosi", mo, 32'hCAFEBABE);
    chk("cafe_lat", lat, 64);
    chk("cafe_dvs", dvs, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
